// File: rtl/sym8psk_unpack_pkg.sv
// Shared baseband definitions for the 8PSK symbol grouper (TX) and unpacker (RX):
// FSM state encoding, bits per symbol and default counter widths.
package sym8psk_unpack_pkg;

    localparam int SYM8PSK_BITS     = 3;
    localparam int DEFAULT_LEN_W    = 12;
    localparam int DEFAULT_SYMCNT_W = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/sym8psk_unpack_if.sv
// Control, symbol handshake and bit-stream signals of the 8PSK unpacker.
// The master modport is the demapper/controller side and the slave modport is the unpacker.
interface sym8psk_unpack_if
    import sym8psk_unpack_pkg::*;
#(
    parameter int LEN_W    = DEFAULT_LEN_W,
    parameter int SYMCNT_W = DEFAULT_SYMCNT_W
);

    logic                start_p;
    logic [LEN_W-1:0]    len;
    logic [2:0]          sym_in;
    logic                sym_valid;
    logic                sym_ready;
    logic                bit_en;
    logic                bit_out;
    logic                bit_valid;
    logic [SYMCNT_W-1:0] symcnt;
    logic                busy;
    logic                done_p;
    logic                underrun;

    modport master (
        output start_p, len, sym_in, sym_valid, bit_en,
        input  sym_ready, bit_out, bit_valid, symcnt, busy, done_p, underrun
    );

    modport slave (
        input  start_p, len, sym_in, sym_valid, bit_en,
        output sym_ready, bit_out, bit_valid, symcnt, busy, done_p, underrun
    );

endinterface

// File: rtl/sym8psk_unpack.sv
// Receive-side 8PSK unpacker: serialises 3-bit symbols into a payload of exactly len bits.
// Define SYM8PSK_UNDERRUN_EN to build the sticky symbol-starvation detector.
module sym8psk_unpack
    import sym8psk_unpack_pkg::*;
#(
    parameter int LEN_W    = DEFAULT_LEN_W,
    parameter int SYMCNT_W = DEFAULT_SYMCNT_W
) (
    input  logic                  clk_6M,
    input  logic                  rstz,
    sym8psk_unpack_if.slave       bus
);

    state_e              state_q, state_d;
    logic [2:0]          shreg_q, shreg_d;
    logic [1:0]          nsym_q, nsym_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    bitcnt_q, bitcnt_d;
    logic [SYMCNT_W-1:0] symcnt_q, symcnt_d;
    logic                bit_out_q, bit_out_d;
    logic                bit_valid_q, bit_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
`ifdef SYM8PSK_UNDERRUN_EN
    logic                underrun_q, underrun_d;
`endif

    logic [LEN_W-1:0]    bitcntInc;
    logic                lastBit;
    logic                symEnd;
    logic                chainLoad;

    // Valid bits carried by the next symbol: a full symbol, or whatever the payload still needs.
    function automatic logic [1:0] nsymFor(input logic [LEN_W-1:0] remaining);
        return (remaining >= LEN_W'(SYM8PSK_BITS)) ? 2'(SYM8PSK_BITS) : remaining[1:0];
    endfunction

    assign bitcntInc = bitcnt_q + LEN_W'(1);
    assign lastBit   = (bitcnt_q == (len_q - LEN_W'(1)));
    assign symEnd    = (nsym_q == 2'd1);
    assign chainLoad = (state_q == SHIFT) && bus.bit_en && symEnd && !lastBit && bus.sym_valid;

    // A symbol offered alongside start_p or during reset must not look accepted.
    assign bus.sym_ready = rstz && !bus.start_p && ((state_q == FETCH) || chainLoad);

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        nsym_d      = nsym_q;
        len_d       = len_q;
        bitcnt_d    = bitcnt_q;
        symcnt_d    = symcnt_q;
        bit_out_d   = bit_out_q;
        bit_valid_d = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
`ifdef SYM8PSK_UNDERRUN_EN
        underrun_d  = underrun_q;
`endif

        if (bus.start_p) begin
            len_d    = bus.len;
            bitcnt_d = '0;
            symcnt_d = '0;
            shreg_d  = '0;
            nsym_d   = '0;
`ifdef SYM8PSK_UNDERRUN_EN
            underrun_d = 1'b0;
`endif
            if (bus.len != '0) begin
                state_d = FETCH;
                busy_d  = 1'b1;
            end else begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                end
                FETCH: begin
                    if (bus.sym_valid) begin
                        shreg_d  = bus.sym_in;
                        nsym_d   = nsymFor(len_q - bitcnt_q);
                        symcnt_d = symcnt_q + SYMCNT_W'(1);
                        state_d  = SHIFT;
                    end
`ifdef SYM8PSK_UNDERRUN_EN
                    else if (bus.bit_en) begin
                        underrun_d = 1'b1;
                    end
`endif
                end
                SHIFT: begin
                    if (bus.bit_en) begin
                        bit_out_d   = shreg_q[0];
                        bit_valid_d = 1'b1;
                        shreg_d     = {1'b0, shreg_q[2:1]};
                        bitcnt_d    = bitcntInc;
                        nsym_d      = nsym_q - 2'd1;
                        if (lastBit) begin
                            state_d = DONE;
                        end else if (chainLoad) begin
                            shreg_d  = bus.sym_in;
                            nsym_d   = nsymFor(len_q - bitcntInc);
                            symcnt_d = symcnt_q + SYMCNT_W'(1);
                        end else if (symEnd) begin
                            state_d = FETCH;
                        end
                    end
                end
                DONE: begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_6M) begin
        if (!rstz) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            nsym_q      <= '0;
            len_q       <= '0;
            bitcnt_q    <= '0;
            symcnt_q    <= '0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            nsym_q      <= nsym_d;
            len_q       <= len_d;
            bitcnt_q    <= bitcnt_d;
            symcnt_q    <= symcnt_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

`ifdef SYM8PSK_UNDERRUN_EN
    always_ff @(posedge clk_6M) begin
        if (!rstz) begin
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= underrun_d;
        end
    end

    assign bus.underrun = underrun_q;
`else
    assign bus.underrun = 1'b0;
`endif

    assign bus.bit_out   = bit_out_q;
    assign bus.bit_valid = bit_valid_q;
    assign bus.symcnt    = symcnt_q;
    assign bus.busy      = busy_q;
    assign bus.done_p    = done_q;

endmodule

// File: doc/sym8psk_unpack.md
Name: sym8psk_unpack

Overview:
- Receive-side counterpart of the transmit 8PSK symbol grouper in the EDR baseband.
- Accepts 3-bit 8PSK symbols from the demapper and serialises them into a payload bit stream of exactly len bits.
- The final symbol may carry only 1 or 2 valid bits.
- Counts accepted symbols and flags end of payload to the packet receive controller.

Parameters:
- LEN_W, 12, width of len and the internal bit counter.
- SYMCNT_W, 11, width of the symcnt output.

Ports:
- clk_6M  in  1  6 MHz baseband clock.
- rstz  in  1  reset; synchronous to clk_6M, active-low.
- start_p  in  1  one-cycle pulse; latches len and begins a payload.
- len  in  LEN_W  payload length in bits; sampled only on start_p.
- sym_in  in  3  8PSK symbol bits; sym_in[0] is transmitted first.
- sym_valid  in  1  sym_in holds a valid symbol.
- sym_ready  out  1  block accepts sym_in this cycle; transfer occurs when sym_valid & sym_ready.
- bit_en  in  1  downstream bit strobe; at most one bit is emitted per strobe.
- bit_out  out  1  serial payload bit.
- bit_valid  out  1  one-cycle pulse; bit_out is valid.
- symcnt  out  SYMCNT_W  number of symbols accepted in the current payload.
- busy  out  1  high from start until done.
- done_p  out  1  one-cycle pulse after the last payload bit.
- underrun  out  1  sticky starvation flag (see Optional Feature).

Behaviour:
- Reset (rstz=0 at a clk_6M edge) sets the state to IDLE and clears every output: bit_out=0, bit_valid=0, symcnt=0, busy=0, done_p=0, underrun=0, sym_ready=0. It also clears the shift register, bit counter and latched len. Reset overrides all other inputs, including mid-payload.
- States:
  - IDLE. start_p with len!=0 → FETCH, busy=1. start_p with len==0 → done_p on the next cycle; stay IDLE; no symbol is fetched.
  - FETCH. sym_ready=1 combinationally. On sym_valid: load shreg<=sym_in; set nsym = min(3, len-bitcount); symcnt+1; → SHIFT.
  - SHIFT. On bit_en, registered on the same edge: bit_out<=shreg[0], bit_valid=1, shreg>>=1, bitcount+1.
    - If that bit completes the payload (bitcount==len-1) → DONE.
    - Else if it completes the symbol and sym_valid=1: sym_ready=1 combinationally that cycle and the next symbol loads with no bubble (stay SHIFT, symcnt+1).
    - Else if it completes the symbol → FETCH.
  - DONE. done_p=1 for one cycle, busy=0, → IDLE. symcnt and bitcount hold their final values until the next start_p.
- Result: for len L, final symcnt = ceil(L/3) and exactly L bit_valid pulses occur. Leftover bits of a partial final symbol are discarded.
- bit_en is ignored in IDLE, FETCH and DONE: no bit is emitted and no counter moves.
- start_p in any non-IDLE state aborts the payload: re-latch len, clear symcnt, bitcount and underrun, → FETCH (or the len==0 path). A symbol offered in the same cycle as start_p is not accepted.
- bitcount and symcnt never wrap within a payload, because len ≤ 2^LEN_W-1.
- All outputs are registered, except sym_ready, which is a combinational decode of state, bit_en, final-bit condition and sym_valid.

Optional Feature:
- Macro: SYM8PSK_UNDERRUN_EN.
- Defined: in FETCH, bit_en=1 with sym_valid=0 sets underrun on the next edge. underrun stays set until start_p or reset. Payload processing continues unaffected.
- Not defined: underrun is tied to 0 and no detection logic is built.

Decomposition:
- Shared baseband package holds:
  - state enum {IDLE, FETCH, SHIFT, DONE};
  - constant SYM8PSK_BITS=3;
  - default LEN_W / SYMCNT_W constants, shared with the transmit-side grouper.
- No sub-module; the block is a flat FSM plus shift register and two counters.

Test Plan:
- len=9; symbols 3'b101, 3'b011, 3'b110 always valid; bit_en every 2nd cycle → bits 1,0,1,1,1,0,0,1,1; no bubble between symbols; symcnt=3; single done_p; busy low after.
- len=10; four symbols → 10 bit_valid pulses; 4th symbol contributes only sym_in[0]; symcnt=4.
- len=0; start_p → done_p exactly 1 cycle later; sym_ready never high; symcnt=0.
- len=6; withhold sym_valid in FETCH across 3 bit_en pulses → no bit_valid during the stall. underrun=1 with SYM8PSK_UNDERRUN_EN, 0 without. Payload then completes normally once symbols arrive.
- len=9; start_p after 4 bits with new len=6 → symcnt restarts from 0; exactly 6 further bits; symcnt=2; one done_p.
- Drive rstz=0 for one edge mid-SHIFT → all outputs 0 on that edge; block idles until the next start_p.
